efpga_config_word_decoder: RTL



---
 rtl/efpga_config_word_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/efpga_config_word_decoder.sv
// Decodes the 32-bit self-write configuration stream into per-row frame writes and frame strobes.
// Optional idle-abort mid-frame is enabled with `define CONFIG_TIMEOUT_EN.
module efpga_config_word_decoder #(
  parameter int          NUMBER_OF_ROWS     = 4,
  parameter int          FRAME_BITS_PER_ROW = 32,
  parameter int          ROW_SELECT_WIDTH   = 5,
  parameter int          DESYNC_FLAG        = 20,
  parameter logic [31:0] SYNC_WORD          = 32'hFAB0FAB1,
  parameter int          TIMEOUT_CYCLES     = 1_200_000
) (
  input  logic                          clk_system_i,
  input  logic                          reset_i,
  input  logic [31:0]                   write_data_i,
  input  logic                          write_strobe_i,
  output logic [31:0]                   frame_address_o,
  output logic [FRAME_BITS_PER_ROW-1:0] frame_data_o,
  output logic [ROW_SELECT_WIDTH-1:0]   row_select_o,
  output logic                          local_strobe_o,
  output logic                          long_frame_strobe_o,
  output logic                          synced_o,
  output logic                          error_o
);

  localparam int RW = $clog2(NUMBER_OF_ROWS + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUMBER_OF_ROWS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] row_cnt;
  logic          is_sync, take_addr, take_data, desync, last_word, last_pend;
  logic          timeout;

  assign is_sync = write_strobe_i && (write_data_i == SYNC_WORD);

`ifdef CONFIG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  // Counts consecutive strobe-less cycles spent in DATA.
  always_ff @(posedge clk_system_i) begin
    if (reset_i || state != DATA || write_strobe_i) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == DATA) && !write_strobe_i && (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_system_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Sync word takes priority everywhere, including over the desync bit it happens to carry.
  always_comb begin
    state_nxt = state;
    take_addr = 1'b0;
    take_data = 1'b0;
    desync    = 1'b0;
    last_word = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
    end else if (write_strobe_i) begin
      case (state)
        IDLE: if (is_sync) state_nxt = ADDR;
        ADDR: begin
          if (is_sync) begin
            state_nxt = ADDR;
          end else if (write_data_i[DESYNC_FLAG]) begin
            desync    = 1'b1;
            state_nxt = IDLE;
          end else begin
            take_addr = 1'b1;
            state_nxt = DATA;
          end
        end
        DATA: begin
          if (is_sync) begin
            state_nxt = ADDR;
          end else begin
            take_data = 1'b1;
            if (row_cnt == ROW_LAST) begin
              last_word = 1'b1;
              state_nxt = ADDR;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_system_i) begin
    if (reset_i) begin
      row_cnt             <= '0;
      frame_address_o     <= '0;
      frame_data_o        <= '0;
      row_select_o        <= '0;
      local_strobe_o      <= 1'b0;
      long_frame_strobe_o <= 1'b0;
      last_pend           <= 1'b0;
      synced_o            <= 1'b0;
      error_o             <= 1'b0;
    end else begin
      local_strobe_o      <= take_data;
      last_pend           <= last_word;
      long_frame_strobe_o <= last_pend;
      synced_o            <= (state_nxt != IDLE);
      if (is_sync) row_cnt <= '0;
      if (take_addr) begin
        frame_address_o <= write_data_i;
        row_cnt         <= '0;
      end
      if (take_data) begin
        frame_data_o <= FRAME_BITS_PER_ROW'(write_data_i);
        row_select_o <= ROW_SELECT_WIDTH'(row_cnt + RW'(1));
        row_cnt      <= row_cnt + RW'(1);
      end
      if (desync || timeout) row_select_o <= '0;
      if (timeout) error_o <= 1'b1;
    end
  end

endmodule
